// File: rtl/alu_muldiv_sequencer.sv
// ---------------------------------------------------------------------------------------------
// alu_muldiv_sequencer
//
// Multi-cycle controller that borrows the shared ALU to execute unsigned RV32M operations
// (MUL, MULHU, DIVU, REMU). Multiply is shift-add and divide is restoring. Each runs for 32
// steps and issues one ALU add or subtract per step. While busy, this block owns the ALU
// inputs (the top level muxes them on alu_grant_o) and stalls the pipeline.
//
// Ports
//   clk_i               system clock, rising edge
//   rst_ni              asynchronous active-low reset
//   halt_i              freeze all state, counter and outputs
//   flush_i             abort any operation in progress; no done, result unchanged
//   start_i             request a new operation; sampled only in idle
//   md_op_i             00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   rs1_val_i           multiplicand / dividend
//   rs2_val_i           multiplier / divisor
//   alu_result_comb_i   unregistered ALU result for the operation driven by this block
//   alu_grant_o         ALU inputs are muxed from this block
//   alu_op_val_o        ALU op code (OpAdd / OpSub, zero when not calculating)
//   alu_operand_a_o     ALU operand A
//   alu_operand_b_o     ALU operand B
//   stall_o             pipeline stall request
//   busy_o              operation in progress
//   done_o              one-cycle pulse, result_o valid
//   result_o            final result, held until the next completed operation
// ---------------------------------------------------------------------------------------------
module alu_muldiv_sequencer #(
    parameter int unsigned XLEN   = 32,
    parameter logic [3:0]  OP_ADD = 4'b0001,
    parameter logic [3:0]  OP_SUB = 4'b0010
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            halt_i,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [1:0]      md_op_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [XLEN-1:0] alu_result_comb_i,
    output logic            alu_grant_o,
    output logic [3:0]      alu_op_val_o,
    output logic [XLEN-1:0] alu_operand_a_o,
    output logic [XLEN-1:0] alu_operand_b_o,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMulhu = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;

    state_e          state_q;
    logic [4:0]      count_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] acc_hi_q;   // multiply: hi, divide: remainder
    logic [XLEN-1:0] acc_lo_q;   // multiply: lo (multiplier), divide: quotient
    logic [XLEN-1:0] opnd_q;     // multiply: multiplicand, divide: divisor
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            is_div;
    logic            in_calc;
    logic [XLEN:0]   div_sh;
    logic            div_ge;
    logic            mul_carry;
    logic [XLEN-1:0] hi_step;
    logic [XLEN-1:0] lo_step;
    logic [XLEN-1:0] final_res;
    logic [XLEN-1:0] div0_res;

    assign is_div  = op_q[1];
    assign in_calc = (state_q == StCalc);

    // One iteration of the shift-add / restoring-divide recurrence.
    always_comb begin
        div_sh    = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_ge    = (div_sh >= {1'b0, opnd_q});
        // The ALU is XLEN wide; the carry out of hi + addend is recovered by wrap detection.
        mul_carry = (alu_result_comb_i < acc_hi_q);
        hi_step   = '0;
        lo_step   = '0;
        if (is_div) begin
            hi_step = div_ge ? alu_result_comb_i : div_sh[XLEN-1:0];
            lo_step = {acc_lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_step = {mul_carry, alu_result_comb_i[XLEN-1:1]};
            lo_step = {alu_result_comb_i[0], acc_lo_q[XLEN-1:1]};
        end
        unique case (op_q)
            OpMul, OpDivu: final_res = lo_step;
            default:       final_res = hi_step;
        endcase
        // Divide by zero: DIVU gives all ones, REMU gives the dividend (kept in acc_lo_q).
        div0_res = op_q[0] ? acc_lo_q : '1;
    end

    // ALU drive is combinational from registered state.
    always_comb begin
        alu_op_val_o    = 4'b0000;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        if (in_calc) begin
            if (is_div) begin
                alu_op_val_o    = OP_SUB;
                alu_operand_a_o = div_sh[XLEN-1:0];
                alu_operand_b_o = opnd_q;
            end else begin
                alu_op_val_o    = OP_ADD;
                alu_operand_a_o = acc_hi_q;
                alu_operand_b_o = acc_lo_q[0] ? opnd_q : '0;
            end
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign stall_o     = busy_o;
    assign alu_grant_o = busy_o;
    assign done_o      = done_q;
    assign result_o    = result_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            count_q  <= '0;
            op_q     <= OpMul;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q <= StIdle;
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (!halt_i) begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q     <= md_op_i;
                        count_q  <= '0;
                        acc_hi_q <= '0;
                        if (md_op_i[1]) begin
                            acc_lo_q <= rs1_val_i;
                            opnd_q   <= rs2_val_i;
                            state_q  <= (rs2_val_i == '0) ? StDone : StCalc;
                        end else begin
                            acc_lo_q <= rs2_val_i;
                            opnd_q   <= rs1_val_i;
                            state_q  <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_hi_q <= hi_step;
                    acc_lo_q <= lo_step;
                    count_q  <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q  <= StDone;
                        done_q   <= 1'b1;
                        result_q <= final_res;
                    end
                end
                StDone: begin
                    // Entered with done_q low only on divide by zero: publish result first.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        done_q   <= 1'b1;
                        result_q <= div0_res;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt, flush, start;
    logic [1:0]  md_op;
    logic [31:0] rs1, rs2, alu_res;
    logic        grant, stall, busy, done;
    logic [3:0]  op_val;
    logic [31:0] opa, opb, result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Reference ALU.
    assign alu_res = (op_val == 4'b0001) ? opa + opb :
                     (op_val == 4'b0010) ? opa - opb : 32'h0;

    alu_muldiv_sequencer dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .halt_i            (halt),
        .flush_i           (flush),
        .start_i           (start),
        .md_op_i           (md_op),
        .rs1_val_i         (rs1),
        .rs2_val_i         (rs2),
        .alu_result_comb_i (alu_res),
        .alu_grant_o       (grant),
        .alu_op_val_o      (op_val),
        .alu_operand_a_o   (opa),
        .alu_operand_b_o   (opb),
        .stall_o           (stall),
        .busy_o            (busy),
        .done_o            (done),
        .result_o          (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          div0;
    } vec_t;

    vec_t vecs[14];

    // Observations from the last run_seq call.
    int          done_cyc, busy_cnt, done_cnt, op_cnt, sig_bad;

    // Issue one op (start high for edge 0) and watch cycles 1.. until done has come and gone.
    // Halt is held for cycles [h0, h0+hl); a stray DIVU-by-zero start is pulsed in cycle sp_at.
    task automatic run_seq(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int h0, input int hl, input int sp_at);
        logic [3:0] code;
        bit         seen;
        code     = op[1] ? 4'b0010 : 4'b0001;
        done_cyc = 0; busy_cnt = 0; done_cnt = 0; op_cnt = 0; sig_bad = 0; seen = 0;
        @(negedge clk);
        md_op = op; rs1 = a; rs2 = b; start = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (!seen) done_cyc = cyc;
                seen = 1;
            end
            if (op_val == code) op_cnt++;
            if (grant !== busy || stall !== busy) sig_bad++;
            start = (cyc == sp_at);
            if (cyc == sp_at) begin
                md_op = 2'b10; rs2 = 32'h0;
            end
            halt = (cyc >= h0 && cyc < h0 + hl);
            if (seen && !busy) break;
        end
        start = 1'b0; halt = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'd7,         32'd6,         32'd42,        1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd14,        1'b0};
        vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'd2,         1'b0};
        vecs[5]  = '{2'b10, 32'd5,         32'd9,         32'd0,         1'b0};
        vecs[6]  = '{2'b11, 32'd5,         32'd9,         32'd5,         1'b0};
        vecs[7]  = '{2'b10, 32'd1234,      32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{2'b11, 32'd1234,      32'd0,         32'd1234,      1'b1};
        vecs[9]  = '{2'b00, 32'h1234_5678, 32'h10,        32'h2345_6780, 1'b0};
        vecs[10] = '{2'b01, 32'h1234_5678, 32'h10,        32'h1,         1'b0};
        vecs[11] = '{2'b01, 32'h8000_0000, 32'd2,         32'h1,         1'b0};
        vecs[12] = '{2'b10, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0};
        vecs[13] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        32'd5,         1'b0};

        rst_n = 1'b0; halt = 1'b0; flush = 1'b0; start = 1'b0;
        md_op = 2'b00; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        check("reset busy",   {31'b0, busy},  32'd0);
        check("reset done",   {31'b0, done},  32'd0);
        check("reset stall",  {31'b0, stall}, 32'd0);
        check("reset grant",  {31'b0, grant}, 32'd0);
        check("reset op_val", {28'b0, op_val}, 32'd0);
        check("reset result", result,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_seq(vecs[i].op, vecs[i].a, vecs[i].b, 1000, 0, 0);
            check($sformatf("v%0d result", i),    result,   vecs[i].exp);
            check($sformatf("v%0d done_cyc", i),  done_cyc, vecs[i].div0 ? 2 : 33);
            check($sformatf("v%0d busy_cnt", i),  busy_cnt, vecs[i].div0 ? 2 : 33);
            check($sformatf("v%0d done_cnt", i),  done_cnt, 1);
            check($sformatf("v%0d op_cnt", i),    op_cnt,   vecs[i].div0 ? 0 : 32);
            check($sformatf("v%0d grant/stall", i), sig_bad, 0);
        end

        // Halt 5 cycles mid-calc plus an ignored start while busy.
        run_seq(2'b00, 32'd7, 32'd6, 10, 5, 5);
        check("halt result",   result,   32'd42);
        check("halt done_cyc", done_cyc, 38);
        check("halt busy_cnt", busy_cnt, 38);
        check("halt done_cnt", done_cnt, 1);

        // Halt while done is high keeps it high.
        run_seq(2'b00, 32'd3, 32'd5, 33, 2, 0);
        check("halt_done result",   result,   32'd15);
        check("halt_done done_cyc", done_cyc, 33);
        check("halt_done done_cnt", done_cnt, 3);
        check("halt_done busy_cnt", busy_cnt, 35);

        // Flush at count=10 (cycle 11).
        @(negedge clk);
        md_op = 2'b00; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        begin
            int dseen = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (done || busy) dseen++;
            end
            check("flush no done", dseen, 0);
        end
        check("flush result kept", result, 32'd15);
        run_seq(2'b10, 32'd100, 32'd7, 1000, 0, 0);
        check("post-flush result",   result,   32'd14);
        check("post-flush done_cyc", done_cyc, 33);

        // start and flush together in idle: start dropped.
        @(negedge clk);
        md_op = 2'b00; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start+flush busy", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("start+flush result", result, 32'd14);

        // Async reset mid-operation.
        md_op = 2'b00; rs1 = 32'd4; rs2 = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy",   {31'b0, busy}, 32'd0);
        check("async rst result", result,        32'd0);
        check("async rst op_val", {28'b0, op_val}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1000, 0, 0);
        check("post-rst result",   result,   32'hFFFF_FFFE);
        check("post-rst done_cyc", done_cyc, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
